// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the LEGv8 datapath.
// The address type is reused by the instruction memory and the next-PC adder.
package pc_pkg;
    localparam int ADDR_W_DEF     = 8;
    localparam int RESET_ADDR_DEF = 0;

    typedef logic [ADDR_W_DEF-1:0] pc_addr_t;
endpackage

// File: rtl/thirty_two_bit_program_counter.sv
// LEGv8 program-counter register.
// Loads address_counter every rising edge and presents it on address one
// cycle later. Synchronous active-high reset forces RESET_ADDR, which is
// truncated to its ADDR_W LSBs.
// Optional macro PC_XCHECK_EN: simulation aid that reports X/Z on
// address_counter or reset at an edge and holds the previous address.
module thirty_two_bit_program_counter
    import pc_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_counter,
    output logic [ADDR_W-1:0] address
);

    localparam logic [ADDR_W-1:0] RST_VAL = ADDR_W'(RESET_ADDR);

    logic [ADDR_W-1:0] address_d;
    logic [ADDR_W-1:0] address_q;

    // Next PC: load upstream value unchanged (hold on unknowns when checking)
    always_comb begin
        address_d = address_counter;
`ifdef PC_XCHECK_EN
        // An X reset falls through to the load path, so hold there too.
        if ($isunknown(reset) || $isunknown(address_counter))
            address_d = address_q;
`endif
    end

    // PC register with synchronous reset; reset has priority over the load
    always_ff @(posedge clk) begin
        if (reset)
            address_q <= RST_VAL;
        else
            address_q <= address_d;
    end

`ifdef PC_XCHECK_EN
    // Report unknown control or address bits seen at an edge
    always @(posedge clk) begin
        if ($isunknown(reset))
            $error("%0t: PC reset is X/Z, address held", $time);
        else if (!reset && $isunknown(address_counter))
            $error("%0t: PC address_counter is X/Z (%h), address held",
                   $time, address_counter);
    end
`endif

    assign address = address_q;

endmodule

// File: tb/tb_thirty_two_bit_program_counter.sv
// Directed bench for the program-counter register.
// A second instance checks truncation of an over-wide RESET_ADDR.
module tb_thirty_two_bit_program_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address_counter;
    logic [7:0] address;
    logic [7:0] address_t;   // RESET_ADDR = 32'h1234 -> 8'h34

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    thirty_two_bit_program_counter #(.ADDR_W(8), .RESET_ADDR(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .address_counter (address_counter),
        .address         (address)
    );

    thirty_two_bit_program_counter #(.ADDR_W(8), .RESET_ADDR(32'h1234)) dut_t (
        .clk             (clk),
        .reset           (reset),
        .address_counter (address_counter),
        .address         (address_t)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1 ns later
    task automatic step(input logic rst, input logic [7:0] ac);
        reset           = rst;
        address_counter = ac;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        address_counter = 8'h00;
        #100;
        @(negedge clk);
        chk("reset_100ns", address, 8'h00);
        chk("reset_trunc", address_t, 8'h34);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h00);
            chk($sformatf("reset_edge%0d", i), address, 8'h00);
        end

        // Release reset and count up
        step(1'b0, 8'h01); chk("load_1", address, 8'h01);
        chk("load_1_t", address_t, 8'h01);
        step(1'b0, 8'h02); chk("load_2", address, 8'h02);
        step(1'b0, 8'h03); chk("load_3", address, 8'h03);

        // Reset mid-sequence
        step(1'b1, 8'h03); chk("reset_mid", address, 8'h00);
        chk("reset_mid_t", address_t, 8'h34);

        // Reset priority over a simultaneous load, then release
        step(1'b1, 8'hA5); chk("reset_prio", address, 8'h00);
        step(1'b0, 8'hA5); chk("load_a5", address, 8'hA5);

        // No combinational path: input change between edges has no effect
        address_counter = 8'h5A;
        #2;
        chk("no_comb_path", address, 8'hA5);
        // Reset asserted between edges has no immediate effect
        reset = 1'b1;
        #1;
        chk("reset_async_none", address, 8'hA5);
        reset = 1'b0;

        // Wrap-around loaded unchanged
        step(1'b0, 8'hFF); chk("load_ff", address, 8'hFF);
        step(1'b0, 8'h00); chk("wrap_00", address, 8'h00);
        step(1'b0, 8'h80); chk("load_80", address, 8'h80);
        step(1'b0, 8'h7F); chk("load_7f", address, 8'h7F);
        chk("load_7f_t", address_t, 8'h7F);

`ifdef PC_XCHECK_EN
        step(1'b0, 8'h12); chk("xchk_pre", address, 8'h12);
        step(1'b0, 8'b0000_xxxx); chk("xchk_hold", address, 8'h12);
        step(1'b0, 8'h34); chk("xchk_recover", address, 8'h34);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
